fft_bitrev_buf: RTL and testbench
=================================

FFT_BITREV_BUF -- requirements
Module: fft_bitrev_buf

Interface
REQ-001 Parameter N, default 4: log2 of frame length; frame = 2^N complex samples.
REQ-002 Parameter W, default 16: width of each real/imag component, two's complement.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_ip  input  1  marks first sample of a frame; qualified by in_valid.
REQ-006 in_valid  input  1  in_re/in_im carry a sample this cycle.
REQ-007 in_re  input  W  real part; sample j of frame is FFT bin bitrev_N(j).
REQ-008 in_im  input  W  imaginary part.
REQ-009 in_ready  output  1  buffer can accept a sample this cycle.
REQ-010 out_valid  output  1  out_* carry a valid natural-order sample.
REQ-011 out_ready  input  1  consumer accepts the sample this cycle.
REQ-012 out_re  output  W  real part, natural bin order.
REQ-013 out_im  output  W  imaginary part.
REQ-014 out_idx  output  N  bin index of presented sample.
REQ-015 out_last  output  1  presented sample is bin 2^N-1.
REQ-016 frame_err  output  1  one-cycle pulse: frame restarted before completion.

Function
REQ-017 Storage SHALL be two banks (ping-pong) of 2^N complex entries, each bank with a full flag; write bank pointer wbank, read bank pointer rbank, write counter wcnt (N bits), read counter rcnt (N bits).
REQ-018 Write FSM SHALL have states IDLE and FILL; IDLE ignores all samples until in_valid&&start_ip, which moves to FILL.
REQ-019 A write SHALL occur when in_valid&&in_ready&&state allows; entry bitrev_N(wcnt) of bank wbank is written (start_ip forces wcnt=0 for that write), then wcnt increments.
REQ-020 On the write with wcnt=2^N-1, full[wbank] SHALL set, wbank SHALL toggle, wcnt SHALL wrap to 0; FSM stays FILL; next sample (start_ip optional) begins next frame.
REQ-021 in_valid&&start_ip with wcnt!=0 in FILL SHALL discard the partial frame, pulse frame_err for one cycle, write that sample as sample 0 of current bank.
REQ-022 in_ready SHALL equal !full[wbank] (registered state, no combinational path from out_ready).
REQ-023 out_valid SHALL equal full[rbank]; out_valid therefore rises in the cycle after the edge that writes the last sample (latency 1 cycle).
REQ-024 out_re/out_im SHALL be entry rcnt of bank rbank, out_idx=rcnt, when out_valid=1; all out_* and out_last SHALL be 0 when out_valid=0.
REQ-025 out_last SHALL be out_valid && rcnt==2^N-1.
REQ-026 On out_valid&&out_ready, rcnt SHALL increment; at rcnt=2^N-1, full[rbank] clears, rbank toggles, rcnt wraps to 0.
REQ-027 While out_valid&&!out_ready, out_* SHALL hold stable.
REQ-028 Write-fill and read-drain in the same cycle SHALL both take effect (different banks); freeing a bank makes in_ready high only from the following cycle.
REQ-029 No arithmetic on data; samples pass bit-exact.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM=IDLE, wcnt=rcnt=0, wbank=rbank=0, both full flags 0, in_ready=1, out_valid=out_last=frame_err=0, out_re=out_im=out_idx=0.
REQ-031 Reset mid-frame or mid-drain SHALL discard all buffered data; no output until a new complete frame after start_ip.

Verification (N=4, W=16)
REQ-032 Frame j=0..15, in_re=j, in_im=-j, start_ip on j=0, out_ready=1 -> out_valid rises 1 cycle after 16th write; out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_im negated, out_idx 0..15, out_last on 16th.
REQ-033 out_ready=0, stream 3 frames back-to-back -> in_ready low after 32 writes, 3rd frame stalled; raise out_ready -> frame 1 then frame 2 output intact, then frame 3 accepted.
REQ-034 start_ip reasserted at wcnt=5 -> frame_err high one cycle, 5 samples discarded, 16 samples from restart produce one correct frame.
REQ-035 10 samples before first start_ip -> ignored; out_valid stays 0 until 16 samples after start_ip.
REQ-036 out_ready toggling 1,0,1,0 -> out_* stable during low cycles; 16 transfers in 32 cycles, order per REQ-032.
REQ-037 rst_n low during drain at out_idx=7 -> out_valid=0 and out_*=0 same cycle asynchronously; after release, no output without new frame.

Source files
------------

// File: rtl/fft_bitrev_buf.sv
// fft_bitrev_buf: ping-pong reorder buffer turning a bit-reversed FFT
// sample stream into natural bin order. One bank fills while the other
// drains; samples pass through untouched.
module fft_bitrev_buf #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_ip,
    input  logic         in_valid,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [N-1:0] out_idx,
    output logic         out_last,
    output logic         frame_err
);

    localparam int DEPTH = 1 << N;
    localparam logic [N-1:0] LAST = '1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   wcnt_q, wcnt_d;
    logic [N-1:0]   rcnt_q, rcnt_d;
    logic           wbank_q, wbank_d;
    logic           rbank_q, rbank_d;
    logic [1:0]     full_q, full_d;
    logic           ferr_q, ferr_d;

    // Storage is not reset: the full flags alone decide what is visible.
    logic [2*W-1:0] mem_q [2][DEPTH];

    logic           wr_en;
    logic           rd_en;
    logic [N-1:0]   wr_cnt;
    logic [N-1:0]   wr_addr;
    logic [2*W-1:0] rd_word;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = x[N-1-i];
        return r;
    endfunction

    // Next-state: write FSM/counters, read counters, bank full flags.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        full_d  = full_q;
        ferr_d  = 1'b0;

        // IDLE only accepts the sample that opens a frame.
        wr_en   = in_valid && in_ready && (state_q == FILL || start_ip);
        wr_cnt  = start_ip ? '0 : wcnt_q;
        wr_addr = bitrev(wr_cnt);
        rd_en   = full_q[rbank_q] && out_ready;

        if (wr_en) begin
            state_d = FILL;
            // A restart mid-frame drops the partial frame in place.
            if (state_q == FILL && start_ip && wcnt_q != '0) ferr_d = 1'b1;
            if (wr_cnt == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wr_cnt + 1'b1;
            end
        end

        // Writing needs an empty bank and reading a full one, so the two
        // updates never target the same flag.
        if (rd_en) begin
            if (rcnt_q == LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcnt_d          = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            ferr_q  <= ferr_d;
        end
    end

    // Sample storage write port, bit-reversed address.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wbank_q][wr_addr] <= {in_re, in_im};
    end

    assign rd_word   = mem_q[rbank_q][rcnt_q];
    assign in_ready  = !full_q[wbank_q];
    assign out_valid = full_q[rbank_q];
    assign out_re    = out_valid ? rd_word[2*W-1:W] : '0;
    assign out_im    = out_valid ? rd_word[W-1:0]   : '0;
    assign out_idx   = out_valid ? rcnt_q : '0;
    assign out_last  = out_valid && (rcnt_q == LAST);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Bench for fft_bitrev_buf: directed scenarios plus random traffic, checked
// against a queue-based model of frames in natural order.
module tb_fft_bitrev_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_ip, in_valid, out_ready;
    logic [15:0] in_re, in_im;
    logic        in_ready, out_valid, out_last, frame_err;
    logic [15:0] out_re, out_im;
    logic [3:0]  out_idx;

    int tests = 0;
    int fails = 0;

    // Model: samples of the frame being collected (input order), and all
    // completed-but-unread samples in natural bin order.
    logic [31:0] part[$];
    logic [31:0] outq[$];
    bit          m_act;
    bit          exp_err;

    fft_bitrev_buf #(.N(4), .W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_ip(start_ip), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
        .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic int rev4(input int x);
        int r = 0;
        for (int b = 0; b < 4; b++) if ((x >> b) & 1) r += 1 << (3 - b);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz = outq.size();
        bit ev = (sz > 0);
        chk("in_ready",  {31'd0, in_ready},  {31'd0, ((sz + 15) / 16) < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("out_re",    {16'd0, out_re},    ev ? {16'd0, outq[0][31:16]} : 32'd0);
        chk("out_im",    {16'd0, out_im},    ev ? {16'd0, outq[0][15:0]}  : 32'd0);
        chk("out_idx",   {28'd0, out_idx},   ev ? 32'((16 - sz % 16) % 16) : 32'd0);
        chk("out_last",  {31'd0, out_last},  {31'd0, ev && (sz % 16 == 1)});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    endtask

    // One clock: drive inputs, advance model, clock, compare.
    task automatic step(input logic v, input logic s, input logic [15:0] re,
                        input logic [15:0] im, input logic ordy, output bit acc);
        int pre = outq.size();
        in_valid = v; start_ip = s; in_re = re; in_im = im; out_ready = ordy;
        acc = v && (((pre + 15) / 16) < 2) && (m_act || s);
        exp_err = 0;
        if (pre > 0 && ordy) void'(outq.pop_front());
        if (acc) begin
            if (s) begin
                if (m_act && part.size() != 0) exp_err = 1;
                part.delete();
                m_act = 1;
            end
            part.push_back({re, im});
            if (part.size() == 16) begin
                for (int k = 0; k < 16; k++) outq.push_back(part[rev4(k)]);
                part.delete();
            end
        end
        @(posedge clk); #1;
        check_all();
    endtask

    // Present one sample until accepted, bounded.
    task automatic feed(input logic s, input logic [15:0] re, input logic [15:0] im,
                        input logic ordy);
        bit acc = 0;
        for (int c = 0; c < 200 && !acc; c++) step(1, s, re, im, ordy, acc);
        if (!acc) chk("feed_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int c = 0; c < n; c++) step(0, 0, 16'h0, 16'h0, ordy, acc);
    endtask

    task automatic do_reset();
        in_valid = 0; start_ip = 0; in_re = 0; in_im = 0; out_ready = 0;
        rst_n = 0;
        #1;
        part.delete(); outq.delete(); m_act = 0; exp_err = 0;
        check_all();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic rnd_frame(input logic ordy);
        for (int j = 0; j < 16; j++) feed(j == 0, 16'($urandom), 16'($urandom), ordy);
    endtask

    initial begin
        bit acc;
        rst_n = 1;
        @(posedge clk); #1;
        do_reset();
        check_all();

        // Samples before any start are ignored.
        for (int j = 0; j < 10; j++) step(1, 0, 16'(100 + j), 16'(j), 1, acc);

        // Ramp frame: re=j, im=-j.
        for (int j = 0; j < 16; j++) feed(j == 0, 16'(j), 16'(-j), 1);
        idle(18, 1);

        // Restart at wcnt=5.
        for (int j = 0; j < 5; j++) feed(j == 0, 16'($urandom), 16'($urandom), 1);
        rnd_frame(1);
        idle(18, 1);

        // Backpressure: two frames fill both banks, third stalls.
        rnd_frame(0);
        rnd_frame(0);
        for (int c = 0; c < 5; c++) step(1, 1, 16'h1234, 16'h5678, 0, acc);
        rnd_frame(1);
        idle(34, 1);

        // out_ready toggling while draining.
        rnd_frame(1);
        for (int c = 0; c < 34; c++) step(0, 0, 16'h0, 16'h0, c[0] == 1'b0, acc);
        idle(4, 1);

        // Random traffic.
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 16'($urandom), 16'($urandom), $urandom_range(0, 2) != 0, acc);

        // Reset mid-drain at index 7.
        do_reset();
        rnd_frame(1);
        for (int c = 0; c < 40 && outq.size() != 9; c++) step(0, 0, 16'h0, 16'h0, 1, acc);
        chk("drain_at_idx7", {28'd0, out_idx}, 32'd7);
        do_reset();
        for (int j = 0; j < 20; j++) step(1, 0, 16'($urandom), 16'($urandom), 1, acc);
        idle(3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
